// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel decoder.
// Finds the 10-bit symbol boundary by bit-slip search on control tokens, then
// classifies each aligned symbol as a control token (2-bit code) or a video
// byte. One instance per TMDS channel; everything runs on clk/clk_en.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS    = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [9:0] tmds_in,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctl,
  output logic       ctl_valid
);

  // Counters only ever compare against (limit - 1), so limit+1 states is ample.
  localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int SRCH_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t              state;
  logic [9:0]          prev;
  logic [TOK_W-1:0]    tok_cnt;
  logic [SRCH_W-1:0]   search_cnt;
  logic [LOSS_W-1:0]   loss_cnt;

  logic [19:0]         window;
  logic [9:0]          aligned;
  logic [7:0]          t_bits;
  logic [7:0]          pixel;
  logic                is_token;
  logic [1:0]          token_code;

  // Extract the symbol at the current slip offset and decode it both ways.
  always_comb begin
    window     = {tmds_in, prev};
    aligned    = 10'(window >> bit_offset);
    is_token   = 1'b1;
    token_code = 2'b00;
    case (aligned)
      10'b1101010100: token_code = 2'b00;
      10'b0010101011: token_code = 2'b01;
      10'b0101010100: token_code = 2'b10;
      10'b1010101011: token_code = 2'b11;
      default:        is_token   = 1'b0;
    endcase
    t_bits   = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    pixel    = 8'h00;
    pixel[0] = t_bits[0];
    for (int i = 1; i < 8; i++) begin
      pixel[i] = aligned[8] ? (t_bits[i] ^ t_bits[i-1]) : ~(t_bits[i] ^ t_bits[i-1]);
    end
  end

  // Alignment state machine with registered classification outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SEARCH;
      prev       <= 10'd0;
      tok_cnt    <= '0;
      search_cnt <= '0;
      loss_cnt   <= '0;
      locked     <= 1'b0;
      bit_offset <= 4'd0;
      de         <= 1'b0;
      data       <= 8'h00;
      ctl        <= 2'b00;
      ctl_valid  <= 1'b0;
    end else if (clk_en) begin
      prev <= tmds_in;
      case (state)
        ST_SEARCH: begin
          de        <= 1'b0;
          ctl_valid <= 1'b0;
          if (is_token && tok_cnt == TOK_LAST) begin
            state      <= ST_LOCKED;
            locked     <= 1'b1;
            loss_cnt   <= '0;
            tok_cnt    <= '0;
            search_cnt <= '0;
            ctl_valid  <= 1'b1;
            ctl        <= token_code;
          end else if (search_cnt == SRCH_LAST) begin
            bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
            search_cnt <= '0;
            tok_cnt    <= '0;
          end else begin
            search_cnt <= search_cnt + 1'b1;
            tok_cnt    <= is_token ? tok_cnt + 1'b1 : '0;
          end
        end
        ST_LOCKED: begin
          if (is_token) begin
            loss_cnt  <= '0;
            ctl_valid <= 1'b1;
            de        <= 1'b0;
            ctl       <= token_code;
          end else if (loss_cnt == LOSS_LAST) begin
            state      <= ST_SEARCH;
            locked     <= 1'b0;
            loss_cnt   <= '0;
            tok_cnt    <= '0;
            search_cnt <= '0;
            de         <= 1'b0;
            ctl_valid  <= 1'b0;
          end else begin
            loss_cnt  <= loss_cnt + 1'b1;
            de        <= 1'b1;
            ctl_valid <= 1'b0;
            data      <= pixel;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed scenarios plus a
// randomized rotated token/data stream, checked against a behavioural model.
module tb_tmds_channel_decoder;

  localparam int LOCK_N   = 16;
  localparam int SEARCH_N = 32;
  localparam int LOSS_N   = 200;
  localparam logic [9:0] TOK00 = 10'b1101010100;

  typedef struct {
    logic [9:0] word;
    bit         is_tok;
    logic [7:0] val;
  } sym_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic [9:0] tmds_in;
  logic       locked;
  logic [3:0] bit_offset;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctl;
  logic       ctl_valid;

  int checks   = 0;
  int failures = 0;

  logic [9:0] token_tab [4];
  int         enc_disp;

  bit         m_locked;
  int         m_offset;
  int         m_tok;
  int         m_search;
  int         m_loss;
  logic [9:0] m_prev;
  bit         m_de;
  bit         m_cv;
  logic [7:0] m_data;
  logic [1:0] m_ctl;

  tmds_channel_decoder #(
    .LOCK_TOKENS   (LOCK_N),
    .SEARCH_TIMEOUT(SEARCH_N),
    .LOSS_TIMEOUT  (LOSS_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .tmds_in   (tmds_in),
    .locked    (locked),
    .bit_offset(bit_offset),
    .de        (de),
    .data      (data),
    .ctl       (ctl),
    .ctl_valid (ctl_valid)
  );

  always #5 clk = ~clk;

  // Inverse of the TMDS transition-minimising step: undo optional inversion,
  // then each data bit is the (x)or of neighbouring bits.
  function automatic logic [7:0] ref_decode(input logic [9:0] q);
    logic [7:0] qm;
    logic [7:0] d;
    qm   = q[9] ? ~q[7:0] : q[7:0];
    d    = 8'h00;
    d[0] = qm[0];
    for (int i = 1; i < 8; i++) d[i] = (qm[i] != qm[i-1]) ? q[8] : ~q[8];
    return d;
  endfunction

  // Serial stream delayed by r bits: low r bits come from the tail of prev_sym.
  function automatic logic [9:0] rotate_word(input logic [9:0] prev_sym, input logic [9:0] cur_sym, input int r);
    logic [9:0] w;
    for (int b = 0; b < 10; b++) begin
      if (b < r) w[b] = prev_sym[10 - r + b];
      else       w[b] = cur_sym[b - r];
    end
    return w;
  endfunction

  task automatic encode_byte(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_disp += (qm[8] ? 0 : -2) + n1q - n0q;
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_offset = 0;
    m_tok    = 0;
    m_search = 0;
    m_loss   = 0;
    m_prev   = 10'd0;
    m_de     = 1'b0;
    m_cv     = 1'b0;
    m_data   = 8'h00;
    m_ctl    = 2'b00;
  endtask

  task automatic model_step(input logic [9:0] w, input logic en);
    logic [19:0] win;
    logic [9:0]  sym;
    int          code;
    if (!en) return;
    win  = {w, m_prev};
    for (int b = 0; b < 10; b++) sym[b] = win[m_offset + b];
    code = -1;
    for (int k = 0; k < 4; k++) if (sym == token_tab[k]) code = k;
    if (!m_locked) begin
      m_tok = (code >= 0) ? m_tok + 1 : 0;
      if (m_tok == LOCK_N) begin
        m_locked = 1'b1;
        m_loss = 0; m_tok = 0; m_search = 0;
      end else begin
        m_search++;
        if (m_search == SEARCH_N) begin
          m_offset = (m_offset + 1) % 10;
          m_search = 0; m_tok = 0;
        end
      end
    end else if (code >= 0) begin
      m_loss = 0;
    end else begin
      m_loss++;
      if (m_loss == LOSS_N) begin
        m_locked = 1'b0;
        m_loss = 0; m_tok = 0; m_search = 0;
      end
    end
    if (m_locked && code >= 0) begin
      m_cv = 1'b1; m_de = 1'b0; m_ctl = code[1:0];
    end else if (m_locked) begin
      m_cv = 1'b0; m_de = 1'b1; m_data = ref_decode(sym);
    end else begin
      m_cv = 1'b0; m_de = 1'b0;
    end
    m_prev = w;
  endtask

  task automatic drive(input logic [9:0] w, input logic en);
    tmds_in = w;
    clk_en  = en;
    @(posedge clk);
    #1;
    model_step(w, en);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    clk_en  = 1'($urandom);
    tmds_in = 10'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_en  = 1'($urandom);
      tmds_in = 10'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({locked, bit_offset, de, data, ctl, ctl_valid} !== 17'd0) begin
        failures++;
        $display("[TB] FAIL reset_values cycle %0d: got %h want 0", i, {locked, bit_offset, de, data, ctl, ctl_valid});
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_offset0_lock();
    for (int n = 1; n <= 20; n++) begin
      drive(TOK00, 1'b1);
      checks++;
      if ({locked, bit_offset, de, data, ctl, ctl_valid} !== {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv}) begin
        failures++;
        $display("[TB] FAIL offset0_model n=%0d: got %h want %h", n, {locked, bit_offset, de, data, ctl, ctl_valid}, {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv});
      end
      if (n == 16 || n == 17) begin
        checks++;
        if (locked !== (n == 17)) begin
          failures++;
          $display("[TB] FAIL offset0_lock_edge n=%0d: got locked=%b want %b", n, locked, (n == 17));
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || bit_offset !== 4'd0 || ctl_valid !== 1'b1 || ctl !== 2'b00 || de !== 1'b0) begin
      failures++;
      $display("[TB] FAIL offset0_final: got locked=%b off=%0d cv=%b ctl=%b de=%b want 1 0 1 00 0", locked, bit_offset, ctl_valid, ctl, de);
    end
  endtask

  task automatic test_video_decode();
    drive(10'h1FF, 1'b1);
    checks++;
    if (ctl_valid !== 1'b1 || de !== 1'b0) begin
      failures++;
      $display("[TB] FAIL video_prev_token: got cv=%b de=%b want 1 0", ctl_valid, de);
    end
    drive(10'h2FF, 1'b1);
    checks++;
    if (de !== 1'b1 || ctl_valid !== 1'b0 || data !== 8'h01) begin
      failures++;
      $display("[TB] FAIL video_1FF: got de=%b cv=%b data=%h want 1 0 01", de, ctl_valid, data);
    end
    drive(TOK00, 1'b1);
    checks++;
    if (de !== 1'b1 || data !== 8'hFE) begin
      failures++;
      $display("[TB] FAIL video_2FF: got de=%b data=%h want 1 FE", de, data);
    end
    drive(TOK00, 1'b1);
    checks++;
    if (ctl_valid !== 1'b1 || de !== 1'b0 || data !== 8'hFE || ctl !== 2'b00) begin
      failures++;
      $display("[TB] FAIL video_data_hold: got cv=%b de=%b data=%h ctl=%b want 1 0 FE 00", ctl_valid, de, data, ctl);
    end
  endtask

  task automatic test_loopback();
    sym_t       seq[$];
    sym_t       s;
    logic [9:0] q;
    bit         last_tok;
    logic [7:0] last_val;
    enc_disp = 0;
    for (int b = 0; b <= 256; b++) begin
      if (b % 50 == 0 || b == 256) begin
        s.word = TOK00; s.is_tok = 1'b1; s.val = 8'h00;
        seq.push_back(s);
      end
      if (b < 256) begin
        encode_byte(8'(b), q);
        s.word = q; s.is_tok = 1'b0; s.val = 8'(b);
        seq.push_back(s);
      end
    end
    last_tok = 1'b1;
    last_val = 8'h00;
    foreach (seq[i]) begin
      drive(seq[i].word, 1'b1);
      checks++;
      if (last_tok ? (ctl_valid !== 1'b1 || de !== 1'b0) : (de !== 1'b1 || data !== last_val)) begin
        failures++;
        $display("[TB] FAIL loopback_byte idx=%0d: got de=%b cv=%b data=%h want tok=%b byte=%h", i, de, ctl_valid, data, last_tok, last_val);
      end
      checks++;
      if ({locked, bit_offset, de, data, ctl, ctl_valid} !== {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv}) begin
        failures++;
        $display("[TB] FAIL loopback_model idx=%0d: got %h want %h", i, {locked, bit_offset, de, data, ctl, ctl_valid}, {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv});
      end
      last_tok = seq[i].is_tok;
      last_val = seq[i].val;
    end
  endtask

  task automatic test_misaligned();
    logic [9:0] w;
    int         lock_cycle;
    do_reset();
    w          = rotate_word(TOK00, TOK00, 3);
    lock_cycle = -1;
    for (int n = 1; n <= 3 * SEARCH_N + LOCK_N + 4; n++) begin
      drive(w, 1'b1);
      if (locked === 1'b1 && lock_cycle < 0) lock_cycle = n;
      checks++;
      if ({locked, bit_offset, de, data, ctl, ctl_valid} !== {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv}) begin
        failures++;
        $display("[TB] FAIL misaligned_model n=%0d: got %h want %h", n, {locked, bit_offset, de, data, ctl, ctl_valid}, {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv});
      end
    end
    checks++;
    if (lock_cycle != 3 * SEARCH_N + LOCK_N || bit_offset !== 4'd3) begin
      failures++;
      $display("[TB] FAIL misaligned_lock: got cycle=%0d off=%0d want cycle=%0d off=3", lock_cycle, bit_offset, 3 * SEARCH_N + LOCK_N);
    end
  endtask

  task automatic test_loss_of_lock();
    int fall_cycle;
    fall_cycle = -1;
    for (int n = 1; n <= LOSS_N + 10; n++) begin
      drive(10'h1FF, 1'b1);
      if (locked !== 1'b1 && fall_cycle < 0) fall_cycle = n;
      checks++;
      if ({locked, bit_offset, de, data, ctl, ctl_valid} !== {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv}) begin
        failures++;
        $display("[TB] FAIL loss_model n=%0d: got %h want %h", n, {locked, bit_offset, de, data, ctl, ctl_valid}, {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv});
      end
    end
    checks++;
    if (fall_cycle != LOSS_N || de !== 1'b0 || ctl_valid !== 1'b0 || bit_offset !== 4'd3) begin
      failures++;
      $display("[TB] FAIL loss_drop: got cycle=%0d de=%b cv=%b off=%0d want cycle=%0d 0 0 3", fall_cycle, de, ctl_valid, bit_offset, LOSS_N);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [9:0] w;
    w = rotate_word(TOK00, TOK00, 3);
    for (int n = 0; n < 20; n++) drive(w, 1'b1);
    for (int n = 0; n < 3; n++) drive(10'h1FF, 1'b1);
    checks++;
    if (locked !== 1'b1 || de !== 1'b1 || bit_offset !== 4'd3) begin
      failures++;
      $display("[TB] FAIL relock_before_reset: got locked=%b de=%b off=%0d want 1 1 3", locked, de, bit_offset);
    end
    do_reset();
    checks++;
    if ({locked, bit_offset, de, data, ctl, ctl_valid} !== 17'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_lock: got %h want 0", {locked, bit_offset, de, data, ctl, ctl_valid});
    end
    for (int n = 1; n <= 20; n++) begin
      drive(TOK00, 1'b1);
      if (n == 16 || n == 17) begin
        checks++;
        if (locked !== (n == 17) || bit_offset !== 4'd0) begin
          failures++;
          $display("[TB] FAIL relock_edge n=%0d: got locked=%b off=%0d want %b 0", n, locked, bit_offset, (n == 17));
        end
      end
    end
  endtask

  task automatic test_clk_en_gating();
    int lock_k;
    do_reset();
    lock_k = -1;
    for (int k = 0; k < 80; k++) begin
      drive(TOK00, (k % 4) == 0);
      if (locked === 1'b1 && lock_k < 0) lock_k = k;
      checks++;
      if ({locked, bit_offset, de, data, ctl, ctl_valid} !== {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv}) begin
        failures++;
        $display("[TB] FAIL clken_model k=%0d: got %h want %h", k, {locked, bit_offset, de, data, ctl, ctl_valid}, {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv});
      end
    end
    checks++;
    if (lock_k != 64) begin
      failures++;
      $display("[TB] FAIL clken_lock_time: got k=%0d want 64", lock_k);
    end
  endtask

  task automatic test_random();
    logic [9:0] prev_sym;
    logic [9:0] sym;
    int         r;
    int         pct;
    do_reset();
    r        = int'($urandom_range(0, 9));
    prev_sym = 10'd0;
    for (int i = 0; i < 600; i++) begin
      pct = (i < 250) ? 97 : 80;
      if ($urandom_range(1, 3) != 1) begin
        if (int'($urandom_range(0, 99)) < pct) sym = token_tab[$urandom_range(0, 3)];
        else                                    sym = 10'($urandom);
        drive(rotate_word(prev_sym, sym, r), 1'b1);
        prev_sym = sym;
      end else begin
        drive(10'($urandom), 1'b0);
      end
      checks++;
      if ({locked, bit_offset, de, data, ctl, ctl_valid} !== {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv}) begin
        failures++;
        $display("[TB] FAIL random_model i=%0d r=%0d: got %h want %h", i, r, {locked, bit_offset, de, data, ctl, ctl_valid}, {m_locked, 4'(m_offset), m_de, m_data, m_ctl, m_cv});
      end
    end
  endtask

  initial begin
    token_tab[0] = 10'b1101010100;
    token_tab[1] = 10'b0010101011;
    token_tab[2] = 10'b0101010100;
    token_tab[3] = 10'b1010101011;
    enc_disp = 0;
    reset    = 1'b1;
    clk_en   = 1'b0;
    tmds_in  = 10'd0;
    model_reset();
    #2;
    test_reset();
    test_offset0_lock();
    test_video_decode();
    test_loopback();
    test_misaligned();
    test_loss_of_lock();
    test_reset_mid_lock();
    test_clk_en_gating();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
